tex_uart_tx: RTL

Downstream consumer of the TeX transform stage: accepts (lhs, rhs) character pairs as the transformer walks a line of the transform table, queues them, and serialises the selected characters onto a UART 8N1 line. A mode input selects whether the input, the transformed character, or both are emitted. An end-of-line flag on a pair appends CR LF. This block is the only path from the transform datapath to the chip's serial output pin.

---
 rtl/tex_pkg.sv | 56 +++++
 rtl/tex_pair_fifo.sv | 56 +++++
 rtl/tex_uart_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tex_pkg.sv
// Shared types and constants for the TeX transform datapath and its UART output stage.
package tex_pkg;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   // Output selection; encoding 3 is treated like MODE_RHS.
   localparam logic [1:0] MODE_RHS  = 2'd0;
   localparam logic [1:0] MODE_LHS  = 2'd1;
   localparam logic [1:0] MODE_BOTH = 2'd2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // One transform-table pair as produced by the transformer stage.
   typedef struct packed {
      logic [7:0] lhs;
      logic [7:0] rhs;
      logic       eol;
   } tex_pair_t;

   localparam int PAIR_W = $bits(tex_pair_t);

   // Index of the last byte in an entry's emit sequence (0..3).
   function automatic logic [1:0] emit_last_idx(input logic [1:0] mode, input logic eol);
      logic [1:0] last;
      last = (mode == MODE_BOTH) ? 2'd1 : 2'd0;
      if (eol) begin
         last = last + 2'd2;
      end
      return last;
   endfunction

   // Byte at position idx of an entry's emit sequence: selected characters, then CR LF.
   function automatic logic [7:0] emit_byte(input tex_pair_t pair, input logic [1:0] mode,
                                            input logic [1:0] idx);
      logic [1:0] chars_last;
      logic [7:0] b;
      chars_last = (mode == MODE_BOTH) ? 2'd1 : 2'd0;
      if (idx == 2'd0) begin
         b = (mode == MODE_LHS || mode == MODE_BOTH) ? pair.lhs : pair.rhs;
      end else if (idx <= chars_last) begin
         b = pair.rhs;
      end else if (idx == chars_last + 2'd1) begin
         b = CHAR_CR;
      end else begin
         b = CHAR_LF;
      end
      return b;
   endfunction

endpackage

// File: rtl/tex_pair_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head entry is visible combinationally on rd_data.
module tex_pair_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_reg;
   logic [PTR_W:0]   rd_ptr_reg;
   logic             push;
   logic             pop;

   assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                  (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);

   // A full queue refuses writes even if a pop happens on the same edge.
   assign push = wr_en && !full;
   assign pop  = rd_en && !empty;

   assign rd_data = mem[rd_ptr_reg[PTR_W-1:0]];

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
      end
   end

   // Read/write pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tex_uart_tx.sv
// Queues (lhs, rhs, eol) pairs and serialises the selected characters as UART 8N1.
module tex_uart_tx
   import tex_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_lhs,
   input  logic [7:0] in_rhs,
   input  logic       in_eol,
   input  logic [1:0] mode,
   output logic       tx,
   output logic       busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tex_pair_t          wr_pair;
   tex_pair_t          head_pair;
   logic [PAIR_W-1:0]  fifo_rd_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;

   tx_state_t          state_reg,    state_next;
   logic [BAUD_W-1:0]  baud_reg,     baud_next;
   logic [2:0]         bit_idx_reg,  bit_idx_next;
   logic [7:0]         shift_reg,    shift_next;
   logic               tx_reg,       tx_next;
   logic [1:0]         seq_idx_reg,  seq_idx_next;
   logic [1:0]         mode_lat_reg, mode_lat_next;

   logic [1:0]         eff_mode;
   logic               baud_done;
   logic [2:0]         bit_idx_inc;

   assign wr_pair.lhs = in_lhs;
   assign wr_pair.rhs = in_rhs;
   assign wr_pair.eol = in_eol;
   assign head_pair   = tex_pair_t'(fifo_rd_data);

   tex_pair_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAIR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_valid),
      .wr_data (wr_pair),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign busy     = !fifo_empty || (state_reg != TX_IDLE);
   assign tx       = tx_reg;

   // The live mode applies only to an entry's first byte; later bytes use the latched copy.
   assign eff_mode    = (seq_idx_reg == 2'd0) ? mode : mode_lat_reg;
   assign baud_done   = (baud_reg == BAUD_LAST);
   assign bit_idx_inc = bit_idx_reg + 3'd1;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= TX_IDLE;
         baud_reg     <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         seq_idx_reg  <= '0;
         mode_lat_reg <= '0;
      end else begin
         state_reg    <= state_next;
         baud_reg     <= baud_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         seq_idx_reg  <= seq_idx_next;
         mode_lat_reg <= mode_lat_next;
      end
   end

   // Emit sequencer and UART framing; the entry is popped when its final byte loads.
   always_comb begin
      state_next    = state_reg;
      baud_next     = baud_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      seq_idx_next  = seq_idx_reg;
      mode_lat_next = mode_lat_reg;
      fifo_pop      = 1'b0;

      case (state_reg)
         TX_IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               shift_next    = emit_byte(head_pair, eff_mode, seq_idx_reg);
               tx_next       = 1'b0;
               baud_next     = '0;
               bit_idx_next  = '0;
               mode_lat_next = eff_mode;
               state_next    = TX_START;
               if (seq_idx_reg == emit_last_idx(eff_mode, head_pair.eol)) begin
                  fifo_pop     = 1'b1;
                  seq_idx_next = 2'd0;
               end else begin
                  seq_idx_next = seq_idx_reg + 2'd1;
               end
            end
         end
         TX_START: begin
            if (baud_done) begin
               baud_next  = '0;
               tx_next    = shift_reg[0];
               state_next = TX_DATA;
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end
         TX_DATA: begin
            if (baud_done) begin
               baud_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = TX_STOP;
               end else begin
                  bit_idx_next = bit_idx_inc;
                  tx_next      = shift_reg[bit_idx_inc];
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end
         TX_STOP: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = TX_IDLE;
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end
         default: begin
            state_next = TX_IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

endmodule
